mod_counter: RTL and testbench

Parametrised modulo-N up/down counter: the general successor to the game's fixed 4-bit event counter. It is used for the deck position (mod 52), turn/round indexing and cascaded score digits. It adds configurable width and modulus, direction, parallel load, a terminal-count output for cascading and a sticky wrap flag. It sits in the game-control datapath, driven by the FSM's one-cycle strobes.

---
 rtl/game_pkg.sv | 18 +
 rtl/mod_counter_next.sv | 60 ++++++
 rtl/mod_counter.sv | 83 ++++++++
 tb/tb_mod_counter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// ============================================================================
// Module   : game_pkg
// Purpose  : Shared game-control constants: deck geometry and count direction.
// Revision : 1.0
// ============================================================================
`default_nettype none

package game_pkg;

    localparam int DECK_SIZE  = 52;
    localparam int DECK_IDX_W = 6;

    localparam logic CNT_UP = 1'b1;
    localparam logic CNT_DN = 1'b0;

endpackage

`default_nettype wire

// File: rtl/mod_counter_next.sv
// ============================================================================
// Module   : mod_counter_next
// Purpose  : Combinational modulo-N next value and boundary detect.
//            MOD_COUNTER_SAT_EN selects saturation instead of wrap at the boundary.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mod_counter_next
    import game_pkg::*;
#(
    parameter int WIDTH   = DECK_IDX_W,
    parameter int MODULUS = DECK_SIZE
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_up,
    output logic [WIDTH-1:0] o_next,
    output logic             o_boundary
);

    localparam logic [WIDTH-1:0] c_max  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);

    logic w_at_max;
    logic w_at_zero;

    assign w_at_max   = (i_q == c_max);
    assign w_at_zero  = (i_q == c_zero);
    assign o_boundary = (i_up == CNT_UP) ? w_at_max : w_at_zero;

    // Boundary is tested before stepping so no WIDTH overflow is ever relied upon.
    always_comb begin
        o_next = i_q;
        if (i_up == CNT_UP) begin
            if (!w_at_max) begin
                o_next = i_q + c_one;
            end else begin
`ifdef MOD_COUNTER_SAT_EN
                o_next = c_max;
`else
                o_next = c_zero;
`endif
            end
        end else begin
            if (!w_at_zero) begin
                o_next = i_q - c_one;
            end else begin
`ifdef MOD_COUNTER_SAT_EN
                o_next = c_zero;
`else
                o_next = c_max;
`endif
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mod_counter.sv
// ============================================================================
// Module   : mod_counter
// Purpose  : Modulo-N up/down counter with load, clear, cascade carry and a
//            sticky wrap flag. MOD_COUNTER_SAT_EN makes boundary steps saturate.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mod_counter
    import game_pkg::*;
#(
    parameter int WIDTH     = DECK_IDX_W,
    parameter int MODULUS   = DECK_SIZE,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             carry,
    output logic             wrapped
);

    localparam logic [WIDTH-1:0] c_max       = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] c_reset_val = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] r_count_q;
    logic [WIDTH-1:0] w_count_d;
    logic             r_wrapped_q;
    logic             w_wrapped_d;
    logic [WIDTH-1:0] w_step_val;
    logic             w_boundary;

    mod_counter_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .i_q        (r_count_q),
        .i_up       (up),
        .o_next     (w_step_val),
        .o_boundary (w_boundary)
    );

    always_comb begin
        w_count_d   = r_count_q;
        w_wrapped_d = r_wrapped_q;
        if (clear) begin
            w_count_d   = c_reset_val;
            w_wrapped_d = 1'b0;
        end else if (load) begin
            // Out-of-range loads clamp to the top of the count range.
            w_count_d = (load_val > c_max) ? c_max : load_val;
        end else if (enable) begin
            w_count_d = w_step_val;
            if (w_boundary) begin
                w_wrapped_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count_q   <= c_reset_val;
            r_wrapped_q <= 1'b0;
        end else begin
            r_count_q   <= w_count_d;
            r_wrapped_q <= w_wrapped_d;
        end
    end

    assign q       = r_count_q;
    assign wrapped = r_wrapped_q;
    assign tc      = w_boundary;
    assign carry   = w_boundary & enable & ~load & ~clear;

endmodule

`default_nettype wire

// File: tb/tb_mod_counter.sv
// ============================================================================
// Module   : tb_mod_counter
// Purpose  : Self-checking bench for mod_counter (deck counter + decimal cascade).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mod_counter;

`ifdef MOD_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, clear, load, enable, up;
    logic [5:0] load_val;
    logic [5:0] q;
    logic       tc, carry, wrapped;

    logic       casc_en;
    logic [3:0] lo_q, hi_q, p2_q;
    logic       lo_tc, lo_carry, lo_w;
    logic       hi_tc, hi_carry, hi_w;
    logic       p2_tc, p2_carry, p2_w;

    mod_counter u_dut (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .load(load),
        .load_val(load_val), .up(up), .q(q), .tc(tc), .carry(carry), .wrapped(wrapped)
    );

    mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_lo (
        .clk(clk), .reset(reset), .enable(casc_en), .clear(1'b0), .load(1'b0),
        .load_val(4'd0), .up(1'b1), .q(lo_q), .tc(lo_tc), .carry(lo_carry), .wrapped(lo_w)
    );

    mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_hi (
        .clk(clk), .reset(reset), .enable(lo_carry), .clear(1'b0), .load(1'b0),
        .load_val(4'd0), .up(1'b1), .q(hi_q), .tc(hi_tc), .carry(hi_carry), .wrapped(hi_w)
    );

    mod_counter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) u_p2 (
        .clk(clk), .reset(reset), .enable(casc_en), .clear(1'b0), .load(1'b0),
        .load_val(4'd0), .up(1'b1), .q(p2_q), .tc(p2_tc), .carry(p2_carry), .wrapped(p2_w)
    );

    typedef struct {
        logic       rst, clr, ld, en, u;
        logic [5:0] lv;
        logic [5:0] eq;
        logic       ew;
        string      nm;
    } vec_t;

    typedef struct {
        logic [5:0] q;
        logic       w;
        string      nm;
    } exp_t;

    exp_t       sbq[$];
    vec_t       tbl[$];
    logic [5:0] m_q;
    int         total = 0;
    int         bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic clr, input logic ld,
                                input logic en, input logic u, input logic [5:0] lv,
                                input logic [5:0] eq, input logic ew, input string nm);
        vec_t v;
        v.rst = rst; v.clr = clr; v.ld = ld; v.en = en; v.u = u;
        v.lv = lv; v.eq = eq; v.ew = ew; v.nm = nm;
        return v;
    endfunction

    // Drive one vector, check combinational tc/carry, then the registered result.
    task automatic step(input vec_t v);
        exp_t e;
        logic etc;
        @(negedge clk);
        reset = v.rst; clear = v.clr; load = v.ld; enable = v.en; up = v.u; load_val = v.lv;
        #1;
        etc = (v.u && m_q == 6'd51) || (!v.u && m_q == 6'd0);
        chk({v.nm, " tc"}, 32'(tc), 32'(etc));
        chk({v.nm, " carry"}, 32'(carry), 32'(etc & v.en & ~v.ld & ~v.clr));
        e.q = v.eq; e.w = v.ew; e.nm = v.nm;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk({e.nm, " q"}, 32'(q), 32'(e.q));
        chk({e.nm, " wrapped"}, 32'(wrapped), 32'(e.w));
        m_q = e.q;
    endtask

    initial begin
        logic [3:0] m_lo, m_hi, m_p2;
        logic       m_p2w;
        logic       e_lo_c, e_hi_c;
        int         pulses;

        reset = 1'b1; clear = 1'b0; load = 1'b0; enable = 1'b0; up = 1'b1;
        load_val = 6'd0; casc_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset q", 32'(q), 32'd0);
        chk("reset wrapped", 32'(wrapped), 32'd0);
        chk("reset tc up", 32'(tc), 32'd0);
        chk("reset carry", 32'(carry), 32'd0);
        up = 1'b0;
        #1;
        chk("reset tc down", 32'(tc), 32'd1);
        m_q = 6'd0;

        for (int i = 0; i < 52; i++) begin
            if (i == 51)
                step(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0, SAT ? 6'd51 : 6'd0, 1'b1, "up52"));
            else
                step(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 6'(i + 1), 1'b0, "up52"));
        end

        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd0,  6'd0,  1'b0, "clear"));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  SAT ? 6'd0 : 6'd51, 1'b1, "down_at_0"));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd0,  6'd0,  1'b0, "clear2"));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd60, 6'd51, 1'b0, "load60_clamp"));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'd17, 6'd17, 1'b0, "load17_en"));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  6'd16, 1'b0, "down1"));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0,  6'd17, 1'b0, "up1"));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd17, 1'b0, "hold"));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd30, 6'd30, 1'b0, "load30"));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'd9,  6'd0,  1'b0, "clr_ld_en"));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd63, 6'd51, 1'b0, "load63_clamp"));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0,  SAT ? 6'd51 : 6'd0, 1'b1, "up_at_51"));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd5,  6'd5,  1'b1, "load_keeps_w"));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'd51, 6'd51, 1'b1, "load51_en"));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd0,  6'd0,  1'b0, "clear3"));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd19, 6'd19, 1'b0, "load19"));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0,  6'd20, 1'b0, "to20"));
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 6'd40, 6'd0,  1'b0, "reset_mid"));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0,  6'd1,  1'b0, "after_rst1"));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0,  6'd2,  1'b0, "after_rst2"));
        foreach (tbl[i]) step(tbl[i]);

        // Decimal cascade plus a power-of-two modulus counting in lockstep.
        @(negedge clk);
        reset = 1'b1; enable = 1'b0; clear = 1'b0; load = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        m_lo = 4'd0; m_hi = 4'd0; m_p2 = 4'd0; m_p2w = 1'b0; pulses = 0;
        chk("casc reset lo", 32'(lo_q), 32'd0);
        chk("casc reset hi", 32'(hi_q), 32'd0);
        casc_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #1;
            e_lo_c = (m_lo == 4'd9);
            e_hi_c = e_lo_c && (m_hi == 4'd9);
            chk("casc lo carry", 32'(lo_carry), 32'(e_lo_c));
            chk("casc hi carry", 32'(hi_carry), 32'(e_hi_c));
            if (hi_carry === 1'b1) pulses++;
            if (m_lo == 4'd9) begin
                m_lo = SAT ? 4'd9 : 4'd0;
                if (m_hi == 4'd9) m_hi = SAT ? 4'd9 : 4'd0;
                else              m_hi = m_hi + 4'd1;
            end else begin
                m_lo = m_lo + 4'd1;
            end
            if (m_p2 == 4'd15) begin
                m_p2  = SAT ? 4'd15 : 4'd0;
                m_p2w = 1'b1;
            end else begin
                m_p2 = m_p2 + 4'd1;
            end
            @(posedge clk);
            #1;
            chk("casc lo q", 32'(lo_q), 32'(m_lo));
            chk("casc hi q", 32'(hi_q), 32'(m_hi));
            chk("pow2 q", 32'(p2_q), 32'(m_p2));
            chk("pow2 wrapped", 32'(p2_w), 32'(m_p2w));
            @(negedge clk);
        end
        casc_en = 1'b0;
`ifndef MOD_COUNTER_SAT_EN
        chk("casc hi carry pulses", 32'(pulses), 32'd1);
        chk("casc final pair", 32'({hi_q, lo_q}), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
